// File: rtl/mult_result_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mult_result_collector_pkg                                        |
// | Brief   : Shared sizing for mult_pipeline and its result collector.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mult_result_collector_pkg;

    localparam int W_DEF     = 24;
    localparam int LAT_DEF   = 10;
    localparam int DEPTH_DEF = 16;
    localparam int CNT_W     = $clog2(DEPTH_DEF) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage : mult_result_collector_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo                                                        |
// | Brief   : Single-clock FIFO, registered storage with combinational read.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign empty   = (r_count == '0);
    assign full    = (r_count == CNT_W'(DEPTH));

endmodule : sync_fifo
`default_nettype wire

// File: rtl/mult_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mult_result_collector                                            |
// | Brief   : Credit-gated capture of non-stalling multiply pipeline results.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mult_result_collector
    import mult_result_collector_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_req,
    output logic                      issue_ok,
    input  logic [W-1:0]              pipe_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic [$clog2(DEPTH):0]    credits
);

    localparam int L_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [L_CNT_W-1:0] c_cnt_one = L_CNT_W'(1);

    logic [LAT-1:0]     r_vld_sr;
    logic [L_CNT_W-1:0] r_credits;
    logic               w_fire;
    logic               w_pop;
    logic               w_cap;
    logic               w_empty;
    logic               w_full;
    logic [L_CNT_W-1:0] w_count;

    assign issue_ok  = (r_credits != '0);
    assign w_fire    = issue_req & issue_ok;
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_cap     = r_vld_sr[LAT-1];
    assign credits   = r_credits;

    // Valid bit travels alongside the operand so capture lines up with cOut.
    generate
        if (LAT == 1) begin : g_sr_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_vld_sr <= '0;
                else     r_vld_sr <= w_fire;
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_vld_sr <= '0;
                else     r_vld_sr <= {r_vld_sr[LAT-2:0], w_fire};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= L_CNT_W'(DEPTH);
        end else begin
            case ({w_pop, w_fire})
                2'b10:   r_credits <= r_credits + c_cnt_one;
                2'b01:   r_credits <= r_credits - c_cnt_one;
                default: r_credits <= r_credits;
            endcase
        end
    end

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_cap),
        .wr_data (pipe_result),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .count   (w_count),
        .empty   (w_empty),
        .full    (w_full)
    );

    // Credits guarantee room for every in-flight result; a capture into a full FIFO is a bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_cap && w_full))
        else $error("collector capture while FIFO full");

    a_credit_balance: assert property (@(posedge clk) disable iff (rst)
        (int'(r_credits) + int'(w_count) + $countones(r_vld_sr)) == DEPTH)
        else $error("collector credit balance broken");

endmodule : mult_result_collector
`default_nettype wire
